// File: rtl/mem_exc_stage_pkg.sv
// Shared definitions for the memory-stage exception unit: access size
// encodings, default exception vectors, protection limits and the
// capture FSM state type.
// Optional feature macro: MEM_EXC_WRITE_PROTECT_EN (read-only window defaults).
package mem_exc_stage_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;  // behaves as byte

  localparam logic [4:0]  VEC_MISALIGN_DEF = 5'b01011;
  localparam logic [4:0]  VEC_MEMORY_DEF   = 5'b01001;
  localparam logic [31:0] PROT_LIMIT_DEF   = 32'h0001_0000;

`ifdef MEM_EXC_WRITE_PROTECT_EN
  localparam logic [31:0] RO_BASE_DEF  = 32'h0001_0000;
  localparam logic [31:0] RO_LIMIT_DEF = 32'h0002_0000;
`endif

  typedef enum logic {
    CAP_IDLE    = 1'b0,
    CAP_PENDING = 1'b1
  } cap_state_e;

endpackage

// File: rtl/mem_exc_detect.sv
// Combinational data-access fault detection and vector resolution.
// Execute-stage vectors above VEC_MISALIGN outrank local faults; otherwise
// misalignment, then protection, then the execute vector.
// Optional feature macro: MEM_EXC_WRITE_PROTECT_EN (user-write read-only window).
module mem_exc_detect
  import mem_exc_stage_pkg::*;
#(
  parameter int unsigned           ADDR_W       = 32,
  parameter int unsigned           VEC_W        = 5,
  parameter logic [ADDR_W-1:0]     PROT_LIMIT   = PROT_LIMIT_DEF,
  parameter logic [VEC_W-1:0]      VEC_MISALIGN = VEC_MISALIGN_DEF,
  parameter logic [VEC_W-1:0]      VEC_MEMORY   = VEC_MEMORY_DEF
`ifdef MEM_EXC_WRITE_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0]     RO_BASE      = RO_BASE_DEF,
  parameter logic [ADDR_W-1:0]     RO_LIMIT     = RO_LIMIT_DEF
`endif
) (
  input  logic              in_valid,
  input  logic [VEC_W-1:0]  vector_ex,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [1:0]        size,
  input  logic              s_u,
  input  logic              memread,
  input  logic              memwrite,
  output logic [VEC_W-1:0]  vector_res
);

  logic check;
  logic misaligned;
  logic prot_fault;

  // Local fault detection, qualified by a valid memory access
  always_comb begin
    check      = in_valid & (memread | memwrite);
    misaligned = 1'b0;
    case (size)
      SIZE_WORD: misaligned = |data_address[1:0];
      SIZE_HALF: misaligned = data_address[0];
      default:   misaligned = 1'b0;
    endcase
    prot_fault = s_u & (data_address < PROT_LIMIT);
`ifdef MEM_EXC_WRITE_PROTECT_EN
    prot_fault = prot_fault |
                 (s_u & memwrite & (data_address >= RO_BASE) & (data_address < RO_LIMIT));
`endif
  end

  // Priority resolution; an empty slot carries no vector
  always_comb begin
    vector_res = '0;
    if (in_valid) begin
      if (vector_ex > VEC_MISALIGN)     vector_res = vector_ex;
      else if (check && misaligned)     vector_res = VEC_MISALIGN;
      else if (check && prot_fault)     vector_res = VEC_MEMORY;
      else                              vector_res = vector_ex;
    end
  end

endmodule

// File: rtl/mem_exc_stage.sv
// Memory-stage exception unit: EX/MEM -> MEM/WB stage register with
// stall/flush, plus a sticky first-fault capture FSM with req/ack handshake.
// Optional feature macro: MEM_EXC_WRITE_PROTECT_EN (adds RO_BASE/RO_LIMIT).
module mem_exc_stage
  import mem_exc_stage_pkg::*;
#(
  parameter int unsigned           ADDR_W       = 32,
  parameter int unsigned           VEC_W        = 5,
  parameter logic [ADDR_W-1:0]     PROT_LIMIT   = PROT_LIMIT_DEF,
  parameter logic [VEC_W-1:0]      VEC_MISALIGN = VEC_MISALIGN_DEF,
  parameter logic [VEC_W-1:0]      VEC_MEMORY   = VEC_MEMORY_DEF
`ifdef MEM_EXC_WRITE_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0]     RO_BASE      = RO_BASE_DEF,
  parameter logic [ADDR_W-1:0]     RO_LIMIT     = RO_LIMIT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [VEC_W-1:0]  vector_ex,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [1:0]        size,
  input  logic              s_u,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [VEC_W-1:0]  vector_mem,
  output logic              exc_req,
  output logic [VEC_W-1:0]  exc_vector,
  output logic [ADDR_W-1:0] exc_addr,
  output logic              exc_overrun,
  input  logic              exc_ack
);

  logic [VEC_W-1:0]  vector_res;

  logic              out_valid_q,   out_valid_d;
  logic [VEC_W-1:0]  vector_mem_q,  vector_mem_d;
  logic [ADDR_W-1:0] addr_q,        addr_d;
  logic              loaded_q,      loaded_d;
  cap_state_e        state_q,       state_d;
  logic [VEC_W-1:0]  exc_vector_q,  exc_vector_d;
  logic [ADDR_W-1:0] exc_addr_q,    exc_addr_d;
  logic              exc_overrun_q, exc_overrun_d;
  logic              fault;

  mem_exc_detect #(
    .ADDR_W       (ADDR_W),
    .VEC_W        (VEC_W),
    .PROT_LIMIT   (PROT_LIMIT),
    .VEC_MISALIGN (VEC_MISALIGN),
    .VEC_MEMORY   (VEC_MEMORY)
`ifdef MEM_EXC_WRITE_PROTECT_EN
    ,
    .RO_BASE      (RO_BASE),
    .RO_LIMIT     (RO_LIMIT)
`endif
  ) u_detect (
    .in_valid     (in_valid),
    .vector_ex    (vector_ex),
    .data_address (data_address),
    .size         (size),
    .s_u          (s_u),
    .memread      (memread),
    .memwrite     (memwrite),
    .vector_res   (vector_res)
  );

  // Stage register next state: flush beats stall; loaded_q marks a freshly
  // loaded slot so a held slot is never captured twice
  always_comb begin
    out_valid_d  = out_valid_q;
    vector_mem_d = vector_mem_q;
    addr_d       = addr_q;
    loaded_d     = 1'b0;
    if (flush) begin
      out_valid_d  = 1'b0;
      vector_mem_d = '0;
    end else if (!stall) begin
      out_valid_d  = in_valid;
      vector_mem_d = vector_res;
      addr_d       = data_address;
      loaded_d     = 1'b1;
    end
  end

  // Capture FSM: latch the first fault, flag overrun on a second one
  always_comb begin
    fault         = loaded_q & out_valid_q & (vector_mem_q != '0);
    state_d       = state_q;
    exc_vector_d  = exc_vector_q;
    exc_addr_d    = exc_addr_q;
    exc_overrun_d = exc_overrun_q;
    case (state_q)
      CAP_IDLE: begin
        if (fault) begin
          exc_vector_d = vector_mem_q;
          exc_addr_d   = addr_q;
          state_d      = CAP_PENDING;
        end
      end
      CAP_PENDING: begin
        if (exc_ack) begin
          if (fault) begin
            exc_vector_d = vector_mem_q;
            exc_addr_d   = addr_q;
          end else begin
            state_d = CAP_IDLE;
          end
        end else if (fault) begin
          exc_overrun_d = 1'b1;
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      vector_mem_q  <= '0;
      addr_q        <= '0;
      loaded_q      <= 1'b0;
      state_q       <= CAP_IDLE;
      exc_vector_q  <= '0;
      exc_addr_q    <= '0;
      exc_overrun_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      vector_mem_q  <= vector_mem_d;
      addr_q        <= addr_d;
      loaded_q      <= loaded_d;
      state_q       <= state_d;
      exc_vector_q  <= exc_vector_d;
      exc_addr_q    <= exc_addr_d;
      exc_overrun_q <= exc_overrun_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign vector_mem  = vector_mem_q;
  assign exc_req     = (state_q == CAP_PENDING);
  assign exc_vector  = exc_vector_q;
  assign exc_addr    = exc_addr_q;
  assign exc_overrun = exc_overrun_q;

endmodule

// File: tb/tb_mem_exc_stage.sv
// Self-checking bench for mem_exc_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the stage and fault-capture rules.
module tb_mem_exc_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  vector_ex;
  logic [31:0] data_address;
  logic [1:0]  size;
  logic        s_u, memread, memwrite, stall, flush, exc_ack;
  logic        out_valid, exc_req, exc_overrun;
  logic [4:0]  vector_mem, exc_vector;
  logic [31:0] exc_addr;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_exc_stage #(
    .ADDR_W       (32),
    .VEC_W        (5),
    .PROT_LIMIT   (32'h0001_0000),
    .VEC_MISALIGN (5'b01011),
    .VEC_MEMORY   (5'b01001)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .vector_ex    (vector_ex),
    .data_address (data_address),
    .size         (size),
    .s_u          (s_u),
    .memread      (memread),
    .memwrite     (memwrite),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid),
    .vector_mem   (vector_mem),
    .exc_req      (exc_req),
    .exc_vector   (exc_vector),
    .exc_addr     (exc_addr),
    .exc_overrun  (exc_overrun),
    .exc_ack      (exc_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_valid = 0, m_vec = 0, m_addr = 0, m_fresh = 0;
  int unsigned m_pend = 0, m_evec = 0, m_eaddr = 0, m_ovr = 0;

  function automatic int unsigned ref_vector(bit v, int unsigned vex, int unsigned a,
                                             int unsigned sz, bit su, bit rd, bit wr);
    bit acc, mis, prot;
    if (!v) return 0;
    acc  = rd || wr;
    mis  = acc && ((sz == 0 && (a % 4) != 0) || (sz == 1 && (a % 2) == 1));
    prot = acc && su && (a < 32'h0001_0000);
`ifdef MEM_EXC_WRITE_PROTECT_EN
    prot = prot || (acc && su && wr && a >= 32'h0001_0000 && a < 32'h0002_0000);
`endif
    if (vex > 11)  return vex;
    if (mis)       return 11;
    if (prot)      return 9;
    return vex;
  endfunction

  always @(posedge clk) begin
    bit f;
    if (!rst_n) begin
      m_valid = 0; m_vec = 0; m_addr = 0; m_fresh = 0;
      m_pend = 0; m_evec = 0; m_eaddr = 0; m_ovr = 0;
    end else begin
      f = (m_fresh != 0) && (m_valid != 0) && (m_vec != 0);
      if (m_pend != 0) begin
        if (exc_ack) begin
          if (f) begin m_evec = m_vec; m_eaddr = m_addr; end
          else m_pend = 0;
        end else if (f) m_ovr = 1;
      end else if (f) begin
        m_evec = m_vec; m_eaddr = m_addr; m_pend = 1;
      end
      if (flush) begin
        m_valid = 0; m_vec = 0; m_fresh = 0;
      end else if (stall) begin
        m_fresh = 0;
      end else begin
        m_valid = in_valid;
        m_vec   = ref_vector(in_valid, vector_ex, data_address, size, s_u, memread, memwrite);
        m_addr  = data_address;
        m_fresh = 1;
      end
    end
  end

  // Compare process: every negedge once the bench has reset the DUT
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid",   {31'b0, out_valid},   m_valid);
      chk("vector_mem",  {27'b0, vector_mem},  m_vec);
      chk("exc_req",     {31'b0, exc_req},     m_pend);
      chk("exc_vector",  {27'b0, exc_vector},  m_evec);
      chk("exc_addr",    exc_addr,             m_eaddr);
      chk("exc_overrun", {31'b0, exc_overrun}, m_ovr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply(input bit v, input logic [4:0] vex, input logic [31:0] a,
                       input logic [1:0] sz, input bit su, input bit rd, input bit wr);
    in_valid = v; vector_ex = vex; data_address = a; size = sz;
    s_u = su; memread = rd; memwrite = wr;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack();
    exc_ack = 1'b1;
    idle();
    exc_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; vector_ex = 0; data_address = 0; size = 0;
    s_u = 0; memread = 0; memwrite = 0; stall = 0; flush = 0; exc_ack = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // reset state
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_vector_mem", {27'b0, vector_mem}, 32'd0);
    chk("rst_exc_req", {31'b0, exc_req}, 32'd0);
    chk("rst_exc_overrun", {31'b0, exc_overrun}, 32'd0);

    // misaligned supervisor word read -> vector next cycle, req one later
    apply(1'b1, 5'd0, 32'h0002_0002, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("word_mis_vm", {27'b0, vector_mem}, 32'd11);
    chk("model_word_mis", m_vec, 32'd11);
    idle();
    chk("word_mis_req", {31'b0, exc_req}, 32'd1);
    chk("word_mis_addr", exc_addr, 32'h0002_0002);
    chk("word_mis_vec", {27'b0, exc_vector}, 32'd11);
    ack();
    chk("ack_clears_req", {31'b0, exc_req}, 32'd0);

    // half-word alignment
    apply(1'b1, 5'd0, 32'h0002_0003, 2'b01, 1'b0, 1'b0, 1'b1);
    chk("half_odd_vm", {27'b0, vector_mem}, 32'd11);
    apply(1'b1, 5'd0, 32'h0002_0002, 2'b01, 1'b0, 1'b0, 1'b1);
    chk("half_even_vm", {27'b0, vector_mem}, 32'd0);
    idle(); ack();

    // protection boundary
    apply(1'b1, 5'd0, 32'h0000_FFFF, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("user_low_vm", {27'b0, vector_mem}, 32'd9);
    chk("model_user_low", m_vec, 32'd9);
    apply(1'b1, 5'd0, 32'h0000_FFFF, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("sup_low_vm", {27'b0, vector_mem}, 32'd0);
    apply(1'b1, 5'd0, 32'h0001_0000, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("user_limit_vm", {27'b0, vector_mem}, 32'd0);
    idle(); ack();

    // priority of execute vector
    apply(1'b1, 5'b01100, 32'h0002_0001, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("vex_high_vm", {27'b0, vector_mem}, 32'd12);
    apply(1'b1, 5'b00100, 32'h0000_0010, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("vex_low_prot_vm", {27'b0, vector_mem}, 32'd9);
    idle(); ack();

    // back-to-back faults without ack
    do_reset();
    apply(1'b1, 5'd0, 32'h0002_0002, 2'b00, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 5'd0, 32'h0002_0001, 2'b01, 1'b0, 1'b1, 1'b0);
    idle();
    chk("b2b_req", {31'b0, exc_req}, 32'd1);
    chk("b2b_first_addr", exc_addr, 32'h0002_0002);
    chk("b2b_overrun", {31'b0, exc_overrun}, 32'd1);
    ack();
    chk("b2b_ack_req", {31'b0, exc_req}, 32'd0);
    chk("overrun_sticky", {31'b0, exc_overrun}, 32'd1);

    // stalled fault slot captured exactly once
    do_reset();
    apply(1'b1, 5'd0, 32'h0002_0001, 2'b00, 1'b0, 1'b1, 1'b0);
    stall = 1'b1;
    idle(); idle(); idle();
    chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_hold_vm", {27'b0, vector_mem}, 32'd11);
    chk("stall_req", {31'b0, exc_req}, 32'd1);
    chk("stall_no_overrun", {31'b0, exc_overrun}, 32'd0);
    ack();
    chk("stall_ack_req", {31'b0, exc_req}, 32'd0);
    idle();
    chk("stall_no_recapture", {31'b0, exc_req}, 32'd0);
    stall = 1'b0;

    // flush beats stall
    apply(1'b1, 5'd0, 32'h0002_0000, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("pre_flush_valid", {31'b0, out_valid}, 32'd1);
    stall = 1'b1; flush = 1'b1;
    apply(1'b1, 5'd0, 32'h0002_0001, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_vm", {27'b0, vector_mem}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // reset while pending drops the fault
    apply(1'b1, 5'd0, 32'h0002_0003, 2'b00, 1'b0, 1'b1, 1'b0);
    idle();
    chk("pend_before_rst", {31'b0, exc_req}, 32'd1);
    do_reset();
    chk("rst_pend_req", {31'b0, exc_req}, 32'd0);
    chk("rst_pend_vec", {27'b0, exc_vector}, 32'd0);
    chk("rst_pend_addr", exc_addr, 32'd0);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 32'h0000_FFFF);
        1:       a = 32'h0000_FFF0 + $urandom_range(0, 31);
        2:       a = 32'h0001_0000 + $urandom_range(0, 32'h0001_FFFF);
        default: a = $urandom;
      endcase
      rst_n   = ($urandom_range(0, 199) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      exc_ack = ($urandom_range(0, 3) == 0);
      apply(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1; stall = 0; flush = 0; exc_ack = 0;
    idle();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_exc_stage.md
# mem_exc_stage

Registered memory-stage exception unit for the processor pipeline: merges the vector from the execute stage with locally detected data-access faults (misalignment, user-mode access to the protected low region), pipelines the result to write-back, and captures the first fault (vector, address) in a cause register with a request/acknowledge handshake to the exception controller. It is the parametrised successor of the combinational memory-stage vector logic, adding pipeline registers, stall/flush, fixed half-word alignment and sticky fault capture.

## Interface
- ADDR_W, 32, data address width
- VEC_W, 5, exception vector width
- PROT_LIMIT, 32'h0001_0000, user accesses below this address fault
- VEC_MISALIGN, 5'b01011, data misalignment vector
- VEC_MEMORY, 5'b01001, data memory protection vector
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  instruction present in EX/MEM slot
- vector_ex  in  VEC_W  vector from execute stage (0 = none)
- data_address  in  ADDR_W  effective address
- size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as byte)
- s_u  in  1  1 = user mode
- memread, memwrite  in  1 each  access type
- stall  in  1  hold stage registers
- flush  in  1  kill stage contents
- out_valid  out  1  MEM/WB slot valid
- vector_mem  out  VEC_W  resolved vector to write-back
- exc_req  out  1  captured fault pending
- exc_vector  out  VEC_W  captured vector
- exc_addr  out  ADDR_W  captured faulting address
- exc_overrun  out  1  sticky: a fault arrived while one was pending
- exc_ack  in  1  single-cycle acknowledge from exception controller

## Operation
- Access = memread | memwrite. Local detection only when in_valid & access.
- Misaligned: word & addr[1:0]!=0; half & addr[0]==1 (both 01 and 11). Byte never.
- Protection: s_u & (data_address < PROT_LIMIT), unsigned compare.
- Resolve (combinational, priority high→low): vector_ex > VEC_MISALIGN → vector_ex; misaligned → VEC_MISALIGN; protection → VEC_MEMORY; vector_ex nonzero → vector_ex; else 0.
- Stage register: if flush → out_valid=0, vector_mem=0; else if stall → hold; else out_valid=in_valid, vector_mem=resolved (0 when !in_valid). Address held alongside internally.
- Capture FSM, states IDLE/PENDING:
  - IDLE: registered out_valid & vector_mem!=0 → latch exc_vector, exc_addr, go PENDING.
  - PENDING: exc_ack → IDLE; new fault without ack → keep first, set exc_overrun.
  - Ack and new fault same cycle → new fault captured, stay PENDING, overrun not set.
- exc_overrun cleared only by reset.

## Timing
- Reset: out_valid=0, vector_mem=0, exc_req=0, exc_vector=0, exc_addr=0, exc_overrun=0, FSM IDLE.
- Inputs → vector_mem: 1 cycle. vector_mem → exc_req: 1 further cycle (exc_req registered = state PENDING).
- flush beats stall. Stall holds the stage; capture FSM does not re-capture a held slot (capture only on the cycle the slot is loaded).
- Reset mid-PENDING drops the fault; no ack required.
- exc_ack while IDLE ignored.

## Configuration
- MEM_EXC_WRITE_PROTECT_EN defined: adds parameters RO_BASE/RO_LIMIT (defaults 32'h0001_0000/32'h0002_0000); user-mode memwrite in [RO_BASE, RO_LIMIT) raises VEC_MEMORY at protection priority. Undefined: no read-only region, parameters absent, writes checked only against PROT_LIMIT.

## Structure
- Shared package/include: size encodings, VEC_MISALIGN, VEC_MEMORY, PROT_LIMIT default, FSM state encoding.
- One sub-module: mem_exc_detect (combinational detect/resolve); top holds stage register and capture FSM.

## Test plan
- Word read 0x0002_0002, s_u=0, vector_ex=0 → next cycle vector_mem=01011; following cycle exc_req=1, exc_addr=0x0002_0002.
- Half write 0x0002_0003 → 01011 (odd half at 11 faults); half 0x0002_0002 → 0.
- User byte read 0x0000_FFFF → 01001; supervisor same → 0; user 0x0001_0000 → 0.
- vector_ex=5'b01100 with misaligned word → vector_mem=01100; vector_ex=5'b00100, aligned user 0x10 → 01001.
- Two faults back-to-back, no ack → exc_addr = first address, exc_overrun=1; ack then → exc_req=0 next cycle.
- stall held 3 cycles with fault in slot → single capture; flush with stall → out_valid=0, vector_mem=0; rst_n low in PENDING → all outputs 0.
